// File: rtl/operand_issue_ctrl.sv
// Operand-issue controller: register-file read-address selection, scoreboard-based
// RAW/WAW stall, and a one-deep registered issue stage between decode and operand fetch.
module operand_issue_ctrl #(
    parameter int NREGS  = 16,
    parameter int RA_IDX = 15,
    parameter int CNT_W  = 16,
    localparam int IW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             dec_valid,
    output logic             dec_ready,
    input  logic [31:0]      dec_inst,
    input  logic             dec_is_st,
    input  logic             dec_is_ret,
    input  logic             dec_is_imm,
    input  logic             dec_is_wb,
    input  logic             dec_is_call,
    output logic [IW-1:0]    rf_raddr1,
    output logic [IW-1:0]    rf_raddr2,
    output logic             iss_valid,
    input  logic             iss_ready,
    output logic [31:0]      iss_inst,
    output logic [IW-1:0]    iss_dest,
    output logic             iss_dest_en,
    input  logic             wb_valid,
    input  logic [IW-1:0]    wb_addr,
    input  logic             flush,
    output logic [NREGS-1:0] pending,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [IW-1:0] RA = IW'(RA_IDX);

    logic [IW-1:0]    rd;
    logic [IW-1:0]    rs1;
    logic [IW-1:0]    rs2;
    logic [IW-1:0]    dest;
    logic             dest_en;
    logic             src2_used;
    logic             hazard;
    logic             slot_free;
    logic             accept;
    logic [NREGS-1:0] pending_next;

    assign rd  = dec_inst[22 +: IW];
    assign rs1 = dec_inst[18 +: IW];
    assign rs2 = dec_inst[14 +: IW];

    assign rf_raddr1 = dec_is_ret ? RA : rs1;
    assign rf_raddr2 = dec_is_st ? rd : rs2;
    assign src2_used = !dec_is_imm || dec_is_st;
    assign dest      = dec_is_call ? RA : rd;
    assign dest_en   = dec_is_wb || dec_is_call;

    // Hazard looks only at registered pending bits, so a same-cycle writeback
    // cannot release a stall early.
    assign hazard = dec_valid && (pending[rf_raddr1] ||
                                  (src2_used && pending[rf_raddr2]) ||
                                  (dest_en && pending[dest]));

    assign slot_free = !iss_valid || iss_ready;
    assign dec_ready = slot_free && !hazard && !flush;
    assign accept    = dec_valid && dec_ready;

    // Clears are applied before the set so an accept to the same index wins.
    always_comb begin
        pending_next = pending;
        if (wb_valid)
            pending_next[wb_addr] = 1'b0;
        if (flush && iss_valid && iss_dest_en)
            pending_next[iss_dest] = 1'b0;
        if (accept && dest_en)
            pending_next[dest] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_valid   <= 1'b0;
            iss_inst    <= '0;
            iss_dest    <= '0;
            iss_dest_en <= 1'b0;
            pending     <= '0;
            stall_cnt   <= '0;
        end else begin
            if (flush) begin
                iss_valid <= 1'b0;
            end else if (accept) begin
                iss_valid   <= 1'b1;
                iss_inst    <= dec_inst;
                iss_dest    <= dest;
                iss_dest_en <= dest_en;
            end else if (iss_ready) begin
                iss_valid <= 1'b0;
            end
            pending <= pending_next;
            if (hazard && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule
